branch_resolve_unit: RTL and testbench

Back-end counterpart to the front-end static branch predictor. It records every speculative prediction the front end issues (conditional, BL, BX) in an in-order queue. It checks each one against the actual outcome from execute. On a mispredict it flushes wrong-path state and redirects the front end to the correct PC. It also produces the link-register writeback for BL.

---
 rtl/branch_resolve_unit.sv | 191 +++++++++++++++++++
 tb/tb_branch_resolve_unit.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit
// Records every speculative prediction issued by the front end in an
// in-order queue. Each entry is checked against the actual outcome from
// execute. On a mispredict the unit flushes wrong-path work, redirects
// fetch to the correct PC and holds the front end for RECOVER_CYCLES.
// It also produces the link-register writeback for BL.
//
// Ports:
//   clk_i, reset_n_i           clock, synchronous active-low reset
//   pred_*_i / pred_ready_o    prediction enqueue handshake and payload
//   res_*_i                    resolution of the oldest outstanding branch
//   redirect_v_o/redirect_pc_o one-cycle redirect pulse and correct fetch PC
//   flush_o                    one-cycle flush of wrong-path work
//   stall_fe_o                 front end must not fetch (recovery window)
//   link_wr_v_o/link_addr_o    one-cycle BL link writeback and return address
//   count_o                    outstanding entries
//   res_err_o                  one-cycle pulse: resolution with empty queue
//
// State table:
//   state   | meaning
//   NORMAL  | accepting predictions, resolving in order
//   RECOVER | post-redirect hold, front end stalled, queue empty
module branch_resolve_unit #(
  parameter int DEPTH          = 4,
  parameter int ADDR_WIDTH     = 16,
  parameter int RECOVER_CYCLES = 2
) (
  input  logic                       clk_i,
  input  logic                       reset_n_i,
  input  logic                       pred_v_i,
  output logic                       pred_ready_o,
  input  logic                       pred_taken_i,
  input  logic                       pred_link_i,
  input  logic                       pred_ex_i,
  input  logic [ADDR_WIDTH-1:0]      pred_target_pc_i,
  input  logic [ADDR_WIDTH-1:0]      pred_fallthru_pc_i,
  input  logic                       res_v_i,
  input  logic                       res_taken_i,
  input  logic [ADDR_WIDTH-1:0]      res_target_i,
  output logic                       redirect_v_o,
  output logic [ADDR_WIDTH-1:0]      redirect_pc_o,
  output logic                       flush_o,
  output logic                       stall_fe_o,
  output logic                       link_wr_v_o,
  output logic [ADDR_WIDTH-1:0]      link_addr_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       res_err_o
);

  localparam int PW  = $clog2(DEPTH);
  localparam int CW  = PW + 1;
  localparam int RCW = $clog2(RECOVER_CYCLES + 1);

  typedef enum logic {S_NORMAL, S_RECOVER} state_e;

  typedef struct packed {
    logic                  taken;
    logic                  link;
    logic                  ex;
    logic [ADDR_WIDTH-1:0] target;
    logic [ADDR_WIDTH-1:0] fallthru;
  } entry_t;

  entry_t                fifo_q [DEPTH];
  logic [PW-1:0]         head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]         count_q, count_d;
  logic [RCW-1:0]        rec_cnt_q, rec_cnt_d;
  state_e                state_q, state_d;

  logic                  redirect_q, redirect_d, flush_q, flush_d;
  logic                  stall_q, stall_d, link_v_q, link_v_d, err_q, err_d;
  logic [ADDR_WIDTH-1:0] redirect_pc_q, redirect_pc_d, link_addr_q, link_addr_d;

  entry_t head_e;
  logic   res_ok, mispredict, push, pop;

  assign head_e = fifo_q[head_q];
  assign res_ok = res_v_i && (count_q != '0);

  // BX has no static target knowledge, so its target is always checked.
  assign mispredict = res_ok &&
                      ((res_taken_i != head_e.taken) ||
                       (((res_taken_i && head_e.taken) || head_e.ex) &&
                        (res_target_i != head_e.target)));

  assign pred_ready_o = (state_q == S_NORMAL) && (count_q < CW'(DEPTH));
  assign push = pred_v_i && pred_ready_o && !mispredict;
  assign pop  = res_ok && !mispredict;

  // Next-state
  always_comb begin
    state_d   = state_q;
    rec_cnt_d = rec_cnt_q;
    case (state_q)
      S_NORMAL: begin
        if (mispredict) begin
          state_d   = S_RECOVER;
          rec_cnt_d = RCW'(RECOVER_CYCLES - 1);
        end
      end
      S_RECOVER: begin
        if (rec_cnt_q == '0) state_d = S_NORMAL;
        else                 rec_cnt_d = rec_cnt_q - 1'b1;
      end
      default: state_d = S_NORMAL;
    endcase
  end

  // Queue bookkeeping and registered outputs
  always_comb begin
    head_d        = head_q;
    tail_d        = tail_q;
    count_d       = count_q;
    redirect_d    = 1'b0;
    flush_d       = 1'b0;
    link_v_d      = 1'b0;
    err_d         = res_v_i && (count_q == '0);
    redirect_pc_d = redirect_pc_q;
    link_addr_d   = link_addr_q;
    stall_d       = (state_d == S_RECOVER);

    if (res_ok && head_e.link) begin
      link_v_d    = 1'b1;
      link_addr_d = head_e.fallthru;
    end

    if (mispredict) begin
      redirect_d    = 1'b1;
      flush_d       = 1'b1;
      redirect_pc_d = res_taken_i ? res_target_i : head_e.fallthru;
      head_d        = '0;
      tail_d        = '0;
      count_d       = '0;
    end else begin
      if (push) tail_d = tail_q + 1'b1;
      if (pop)  head_d = head_q + 1'b1;
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_q       <= S_NORMAL;
      rec_cnt_q     <= '0;
      head_q        <= '0;
      tail_q        <= '0;
      count_q       <= '0;
      redirect_q    <= 1'b0;
      flush_q       <= 1'b0;
      stall_q       <= 1'b0;
      link_v_q      <= 1'b0;
      err_q         <= 1'b0;
      redirect_pc_q <= '0;
      link_addr_q   <= '0;
    end else begin
      state_q       <= state_d;
      rec_cnt_q     <= rec_cnt_d;
      head_q        <= head_d;
      tail_q        <= tail_d;
      count_q       <= count_d;
      redirect_q    <= redirect_d;
      flush_q       <= flush_d;
      stall_q       <= stall_d;
      link_v_q      <= link_v_d;
      err_q         <= err_d;
      redirect_pc_q <= redirect_pc_d;
      link_addr_q   <= link_addr_d;
    end
  end

  // Payload storage needs no reset; validity is tracked by the pointers.
  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_q[tail_q] <= '{taken:    pred_taken_i,
                          link:     pred_link_i,
                          ex:       pred_ex_i,
                          target:   pred_target_pc_i,
                          fallthru: pred_fallthru_pc_i};
    end
  end

  assign redirect_v_o  = redirect_q;
  assign redirect_pc_o = redirect_pc_q;
  assign flush_o       = flush_q;
  assign stall_fe_o    = stall_q;
  assign link_wr_v_o   = link_v_q;
  assign link_addr_o   = link_addr_q;
  assign count_o       = count_q;
  assign res_err_o     = err_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
module tb_branch_resolve_unit;
  localparam int DEPTH = 4;
  localparam int AW    = 16;
  localparam int RC    = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          pred_v = 1'b0, pred_taken = 1'b0, pred_link = 1'b0, pred_ex = 1'b0;
  logic [AW-1:0] pred_tgt = '0, pred_ft = '0;
  logic          res_v = 1'b0, res_taken = 1'b0;
  logic [AW-1:0] res_tgt = '0;
  logic          pred_ready, redirect_v, flush, stall_fe, link_wr_v, res_err;
  logic [AW-1:0] redirect_pc, link_addr;
  logic [2:0]    count;

  branch_resolve_unit #(.DEPTH(DEPTH), .ADDR_WIDTH(AW), .RECOVER_CYCLES(RC)) dut (
    .clk_i(clk), .reset_n_i(rst_n),
    .pred_v_i(pred_v), .pred_ready_o(pred_ready), .pred_taken_i(pred_taken),
    .pred_link_i(pred_link), .pred_ex_i(pred_ex), .pred_target_pc_i(pred_tgt),
    .pred_fallthru_pc_i(pred_ft), .res_v_i(res_v), .res_taken_i(res_taken),
    .res_target_i(res_tgt), .redirect_v_o(redirect_v), .redirect_pc_o(redirect_pc),
    .flush_o(flush), .stall_fe_o(stall_fe), .link_wr_v_o(link_wr_v),
    .link_addr_o(link_addr), .count_o(count), .res_err_o(res_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: list of outstanding predictions plus remaining stall cycles.
  typedef struct {
    bit          t, l, x;
    bit [AW-1:0] tgt, ft;
  } ent_t;
  ent_t q[$];
  int          rec_left = 0;
  bit          ready_seen, exp_ready, exp_redirect, exp_flush, exp_link, exp_err, exp_stall;
  bit [AW-1:0] exp_rpc = '0, exp_laddr = '0;
  int          exp_count = 0;

  task automatic step(input bit pv, pt, pl, pe, input bit [AW-1:0] ptgt, pft,
                      input bit rv, rt, input bit [AW-1:0] rtgt);
    ent_t e;
    bit   mis;
    @(negedge clk);
    pred_v = pv; pred_taken = pt; pred_link = pl; pred_ex = pe;
    pred_tgt = ptgt; pred_ft = pft;
    res_v = rv; res_taken = rt; res_tgt = rtgt;
    #1;
    ready_seen = pred_ready;
    exp_ready  = (rec_left == 0) && (q.size() < DEPTH);
    exp_redirect = 0; exp_flush = 0; exp_link = 0; exp_err = 0; mis = 0;
    if (rv) begin
      if (q.size() == 0) exp_err = 1;
      else begin
        e = q[0];
        if (e.l) begin exp_link = 1; exp_laddr = e.ft; end
        mis = (rt != e.t) || (rt && e.t && rtgt != e.tgt) || (e.x && rtgt != e.tgt);
        if (mis) begin
          exp_redirect = 1; exp_flush = 1;
          exp_rpc = rt ? rtgt : e.ft;
          q.delete();
        end else void'(q.pop_front());
      end
    end
    if (pv && exp_ready && !mis) q.push_back('{t: pt, l: pl, x: pe, tgt: ptgt, ft: pft});
    if (mis) rec_left = RC;
    else if (rec_left > 0) rec_left--;
    exp_stall = (rec_left > 0);
    exp_count = q.size();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(0, 0, 0, 0, '0, '0, 0, 0, '0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 0;
    pred_v = 0; res_v = 0;
    @(posedge clk);
    #1;
    q.delete(); rec_left = 0; exp_rpc = '0; exp_laddr = '0; exp_count = 0;
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", count); end
    n_checks++; if (redirect_pc !== 16'h0) begin n_fail++; $display("FAIL reset_rpc: got %h want 0000", redirect_pc); end
    n_checks++; if (link_addr !== 16'h0) begin n_fail++; $display("FAIL reset_laddr: got %h want 0000", link_addr); end
    idle();
    n_checks++; if (ready_seen !== 1'b1) begin n_fail++; $display("FAIL idle_ready: got %b want 1", ready_seen); end
    n_checks++; if ({redirect_v, flush, link_wr_v, res_err, stall_fe} !== 5'b0)
      begin n_fail++; $display("FAIL idle_pulses: got %b want 00000", {redirect_v, flush, link_wr_v, res_err, stall_fe}); end
    n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL idle_count: got %0d want 0", count); end
  endtask

  task automatic test_correct_bcc();
    step(1, 1, 0, 0, 16'h0040, 16'h0011, 0, 0, '0);
    n_checks++; if (count !== 3'd1) begin n_fail++; $display("FAIL bcc_count1: got %0d want 1", count); end
    step(0, 0, 0, 0, '0, '0, 1, 1, 16'h0040);
    n_checks++; if (redirect_v !== 1'b0 || flush !== 1'b0)
      begin n_fail++; $display("FAIL bcc_noredir: got %b%b want 00", redirect_v, flush); end
    n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL bcc_count0: got %0d want 0", count); end
  endtask

  task automatic test_mispredict();
    step(1, 1, 0, 0, 16'h0080, 16'h0021, 0, 0, '0);
    step(1, 0, 0, 0, 16'h0090, 16'h0025, 0, 0, '0);
    step(1, 1, 0, 0, 16'h00a0, 16'h0029, 0, 0, '0);
    n_checks++; if (count !== 3'd3) begin n_fail++; $display("FAIL mis_count3: got %0d want 3", count); end
    step(0, 0, 0, 0, '0, '0, 1, 0, 16'h0000);
    n_checks++; if (redirect_v !== 1'b1 || flush !== 1'b1)
      begin n_fail++; $display("FAIL mis_pulse: got %b%b want 11", redirect_v, flush); end
    n_checks++; if (redirect_pc !== 16'h0021) begin n_fail++; $display("FAIL mis_rpc: got %h want 0021", redirect_pc); end
    n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL mis_count0: got %0d want 0", count); end
    n_checks++; if (stall_fe !== 1'b1) begin n_fail++; $display("FAIL mis_stall1: got %b want 1", stall_fe); end
    idle();
    n_checks++; if (redirect_v !== 1'b0 || flush !== 1'b0)
      begin n_fail++; $display("FAIL mis_pulse_end: got %b%b want 00", redirect_v, flush); end
    n_checks++; if (stall_fe !== 1'b1) begin n_fail++; $display("FAIL mis_stall2: got %b want 1", stall_fe); end
    n_checks++; if (ready_seen !== 1'b0) begin n_fail++; $display("FAIL mis_ready_rec: got %b want 0", ready_seen); end
    idle();
    n_checks++; if (stall_fe !== 1'b0) begin n_fail++; $display("FAIL mis_stall3: got %b want 0", stall_fe); end
    idle();
    n_checks++; if (ready_seen !== 1'b1) begin n_fail++; $display("FAIL mis_ready_back: got %b want 1", ready_seen); end
  endtask

  task automatic test_bx_bl();
    step(1, 1, 0, 1, 16'h0100, 16'h0035, 0, 0, '0);
    step(0, 0, 0, 0, '0, '0, 1, 1, 16'h0200);
    n_checks++; if (redirect_v !== 1'b1 || redirect_pc !== 16'h0200)
      begin n_fail++; $display("FAIL bx_redir: got %b/%h want 1/0200", redirect_v, redirect_pc); end
    idle(); idle();
    step(1, 1, 1, 0, 16'h0300, 16'h0031, 0, 0, '0);
    n_checks++; if (count !== 3'd1) begin n_fail++; $display("FAIL bl_count: got %0d want 1", count); end
    step(0, 0, 0, 0, '0, '0, 1, 1, 16'h0300);
    n_checks++; if (link_wr_v !== 1'b1 || link_addr !== 16'h0031)
      begin n_fail++; $display("FAIL bl_link: got %b/%h want 1/0031", link_wr_v, link_addr); end
    n_checks++; if (redirect_v !== 1'b0) begin n_fail++; $display("FAIL bl_noredir: got %b want 0", redirect_v); end
    idle();
    n_checks++; if (link_wr_v !== 1'b0 || link_addr !== 16'h0031)
      begin n_fail++; $display("FAIL bl_hold: got %b/%h want 0/0031", link_wr_v, link_addr); end
  endtask

  task automatic test_full_and_wrap();
    bit [AW-1:0] t;
    int          bad_redir = 0, bad_cnt = 0;
    for (int i = 0; i < 4; i++) step(1, 1, 0, 0, 16'(16'h0400 + i * 16), 16'(16'h0500 + i), 0, 0, '0);
    n_checks++; if (count !== 3'd4) begin n_fail++; $display("FAIL full_count: got %0d want 4", count); end
    step(1, 1, 0, 0, 16'h0abc, 16'h0abd, 1, 1, 16'h0400);
    n_checks++; if (ready_seen !== 1'b0) begin n_fail++; $display("FAIL full_ready: got %b want 0", ready_seen); end
    n_checks++; if (count !== 3'd3) begin n_fail++; $display("FAIL full_drop: got %0d want 3", count); end
    for (int i = 0; i < 10; i++) begin
      t = q[0].tgt;
      step(1, 1, 0, 0, 16'(16'h0600 + i * 4), 16'(16'h0700 + i), 1, 1, t);
      if (redirect_v !== 1'b0) bad_redir++;
      if (count !== 3'd3) bad_cnt++;
    end
    n_checks++; if (bad_redir != 0) begin n_fail++; $display("FAIL wrap_order: got %0d redirects want 0", bad_redir); end
    n_checks++; if (bad_cnt != 0) begin n_fail++; $display("FAIL wrap_count: got %0d bad counts want 0", bad_cnt); end
    for (int i = 0; i < 3; i++) begin
      t = q[0].tgt;
      step(0, 0, 0, 0, '0, '0, 1, 1, t);
      n_checks++; if (redirect_v !== 1'b0) begin n_fail++; $display("FAIL drain_redir: got %b want 0", redirect_v); end
    end
    n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL drain_count: got %0d want 0", count); end
  endtask

  task automatic test_empty_res_and_reset();
    step(0, 0, 0, 0, '0, '0, 1, 1, 16'h1234);
    n_checks++; if (res_err !== 1'b1 || redirect_v !== 1'b0)
      begin n_fail++; $display("FAIL empty_err: got err=%b redir=%b want 1/0", res_err, redirect_v); end
    idle();
    n_checks++; if (res_err !== 1'b0) begin n_fail++; $display("FAIL empty_err_end: got %b want 0", res_err); end
    step(1, 1, 0, 0, 16'h0050, 16'h0051, 0, 0, '0);
    step(0, 0, 0, 0, '0, '0, 1, 0, '0);
    n_checks++; if (stall_fe !== 1'b1) begin n_fail++; $display("FAIL rst_pre_stall: got %b want 1", stall_fe); end
    do_reset();
    n_checks++; if (stall_fe !== 1'b0 || count !== 3'd0)
      begin n_fail++; $display("FAIL rst_in_recover: got stall=%b cnt=%0d want 0/0", stall_fe, count); end
    idle();
    n_checks++; if (ready_seen !== 1'b1) begin n_fail++; $display("FAIL rst_ready: got %b want 1", ready_seen); end
  endtask

  task automatic test_random();
    bit pv, pt, pl, pe, rv, rt;
    bit [AW-1:0] ptgt, pft, rtgt;
    for (int i = 0; i < 400; i++) begin
      pv   = ($urandom_range(0, 9) < 6);
      pe   = ($urandom_range(0, 5) == 0);
      pl   = !pe && ($urandom_range(0, 3) == 0);
      pt   = pe ? 1'b1 : 1'($urandom_range(0, 1));
      ptgt = 16'($urandom_range(0, 7) * 16);
      pft  = 16'($urandom);
      rv   = ($urandom_range(0, 1) == 1);
      rt   = 1'($urandom_range(0, 1));
      rtgt = 16'($urandom_range(0, 7) * 16);
      if (q.size() > 0) begin
        if (q[0].x) rt = 1'b1;
        if ($urandom_range(0, 3) != 0) begin rt = q[0].t; rtgt = q[0].tgt; end
      end
      step(pv, pt, pl, pe, ptgt, pft, rv, rt, rtgt);
      n_checks++; if (ready_seen !== exp_ready) begin n_fail++; $display("FAIL rnd_ready[%0d]: got %b want %b", i, ready_seen, exp_ready); end
      n_checks++; if (redirect_v !== exp_redirect) begin n_fail++; $display("FAIL rnd_redir[%0d]: got %b want %b", i, redirect_v, exp_redirect); end
      n_checks++; if (flush !== exp_flush) begin n_fail++; $display("FAIL rnd_flush[%0d]: got %b want %b", i, flush, exp_flush); end
      n_checks++; if (redirect_pc !== exp_rpc) begin n_fail++; $display("FAIL rnd_rpc[%0d]: got %h want %h", i, redirect_pc, exp_rpc); end
      n_checks++; if (stall_fe !== exp_stall) begin n_fail++; $display("FAIL rnd_stall[%0d]: got %b want %b", i, stall_fe, exp_stall); end
      n_checks++; if (link_wr_v !== exp_link) begin n_fail++; $display("FAIL rnd_link[%0d]: got %b want %b", i, link_wr_v, exp_link); end
      n_checks++; if (link_addr !== exp_laddr) begin n_fail++; $display("FAIL rnd_laddr[%0d]: got %h want %h", i, link_addr, exp_laddr); end
      n_checks++; if (res_err !== exp_err) begin n_fail++; $display("FAIL rnd_err[%0d]: got %b want %b", i, res_err, exp_err); end
      n_checks++; if (count !== 3'(exp_count)) begin n_fail++; $display("FAIL rnd_count[%0d]: got %0d want %0d", i, count, exp_count); end
    end
  endtask

  initial begin
    test_reset();
    test_correct_bcc();
    test_mispredict();
    test_bx_bl();
    test_full_and_wrap();
    test_empty_res_and_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
